// File: rtl/wb_thr_bank.sv
// Wishbone pipelined slave with per-channel threshold registers and live status readback.
// One outstanding request; accept / decode / respond gives one transaction every three cycles.
module wb_thr_bank #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned THR_W   = 16,
  parameter logic [15:0] THR_RST = 16'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic [ADDR_W-1:0]      wb_adr_i,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_we_i,
  input  logic [31:0]            wb_dat_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic                   wb_stall_o,
  output logic [31:0]            wb_dat_o,
  input  logic [NCH*16-1:0]      sts_i,
  output logic [NCH*THR_W-1:0]   thr_o,
  output logic [NCH-1:0]         thr_wr_o
);

  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [ADDR_W:0] NCH_A = (ADDR_W+1)'(NCH);
  localparam logic [THR_W-1:0] THR_RST_W = THR_W'(THR_RST);

  typedef enum logic [1:0] {S_IDLE, S_DEC, S_RSP} state_t;

  state_t              state_q, state_d;
  logic                accept_c;
  logic [ADDR_W-1:0]   adr_q;
  logic                we_q;
  logic [1:0]          sel_q;
  logic [THR_W-1:0]    dat_q;
  logic [THR_W-1:0]    thr_q [NCH];
  logic [15:0]         sts_a [NCH];
  logic                hit_c;
  logic [IDX_W-1:0]    idx_c;
  logic [THR_W-1:0]    mask_c;
  logic [THR_W-1:0]    wr_val_c;
  logic [31:0]         rd_dat_c;
  logic                unused_c;

  assign wb_rty_o = 1'b0;
  assign unused_c = ^{wb_sel_i[3:2], wb_dat_i[31:THR_W], sel_q};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign thr_o[THR_W*k +: THR_W] = thr_q[k];
    assign sts_a[k] = sts_i[16*k +: 16];
  end

  // Sequencing: idle -> decode (T+1) -> respond (T+2)
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          accept_c = 1'b1;
          state_d  = S_DEC;
        end
      end
      S_DEC:   state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decode of the registered request; sel[0] covers bits 7:0, sel[1] the rest
  always_comb begin
    hit_c = ({1'b0, adr_q} < NCH_A);
    idx_c = IDX_W'(adr_q);
    for (int b = 0; b < THR_W; b++) mask_c[b] = sel_q[b/8];
    wr_val_c = (thr_q[idx_c] & ~mask_c) | (dat_q & mask_c);
    rd_dat_c = {sts_a[idx_c], 16'(thr_q[idx_c])};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_stall_o <= 1'b0;
      wb_dat_o   <= '0;
      thr_wr_o   <= '0;
      for (int k = 0; k < NCH; k++) thr_q[k] <= THR_RST_W;
    end else begin
      state_q    <= state_d;
      wb_stall_o <= (state_d != S_IDLE);
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      thr_wr_o   <= '0;
      if (accept_c) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i[1:0];
        dat_q <= wb_dat_i[THR_W-1:0];
      end
      if (state_q == S_DEC) begin
        if (hit_c) begin
          wb_ack_o <= 1'b1;
          if (we_q) begin
            if (mask_c != '0) begin
              thr_q[idx_c]    <= wr_val_c;
              thr_wr_o[idx_c] <= 1'b1;
            end
          end else begin
            wb_dat_o <= rd_dat_c;
          end
        end else begin
          wb_err_o <= 1'b1;
          wb_dat_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_thr_bank.sv
// Randomized self-checking bench for wb_thr_bank against a register-map reference model.
module tb_wb_thr_bank;

  localparam int NCH = 4;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [ADDR_W-1:0] adr = '0;
  logic [3:0]        sel = '0;
  logic [31:0]       wdat = '0;
  logic              ack, err, rty, stall;
  logic [31:0]       rdat;
  logic [63:0]       sts = '0;
  logic [63:0]       thr;
  logic [3:0]        thr_wr;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [15:0] thr_m [NCH];
  logic [31:0] dat_m;

  // observations of one transaction
  logic o_stall1, o_resp1, o_ack2, o_err2, o_stall2, o_resp3, o_stall3;
  logic [31:0] o_dat;
  logic [3:0]  o_wr2, o_wr3;
  logic [63:0] o_thr;

  wb_thr_bank #(.NCH(NCH), .ADDR_W(ADDR_W), .THR_W(16), .THR_RST(16'h0)) dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .wb_stall_o(stall), .wb_dat_o(rdat), .sts_i(sts), .thr_o(thr),
    .thr_wr_o(thr_wr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] thr_exp();
    return {thr_m[3], thr_m[2], thr_m[1], thr_m[0]};
  endfunction

  function automatic logic [15:0] sts_of(input int k);
    logic [63:0] s;
    s = sts;
    return s[16*k +: 16];
  endfunction

  // Apply the register-map rules to the model; returns expected pulse vector
  function automatic logic [3:0] model_txn(input logic [ADDR_W-1:0] a, input logic w,
                                           input logic [3:0] s, input logic [31:0] d);
    logic [3:0] p;
    int k;
    p = '0;
    k = int'(a);
    if (k >= NCH) begin
      dat_m = 32'h0;
    end else if (w) begin
      if (s[0]) thr_m[k][7:0] = d[7:0];
      if (s[1]) thr_m[k][15:8] = d[15:8];
      if (s[1:0] != 2'b00) p[k] = 1'b1;
    end else begin
      dat_m = {sts_of(k), thr_m[k]};
    end
    return p;
  endfunction

  task automatic txn(input logic [ADDR_W-1:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; wdat = d;
    @(posedge clk); #1;
    o_stall1 = stall; o_resp1 = ack | err;
    cyc = 1'b0; stb = 1'b0; wdat = $urandom; sel = 4'($urandom);
    @(posedge clk); #1;
    o_ack2 = ack; o_err2 = err; o_dat = rdat; o_wr2 = thr_wr; o_thr = thr; o_stall2 = stall;
    @(posedge clk); #1;
    o_resp3 = ack | err; o_stall3 = stall; o_wr3 = thr_wr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({ack, err, stall, rty} !== 4'b0) begin errors++; $display("FAIL reset_ctl got %b want 0000", {ack, err, stall, rty}); end
    checks++;
    if (rdat !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", rdat); end
    checks++;
    if (thr !== 64'h0 || thr_wr !== 4'h0) begin errors++; $display("FAIL reset_thr got %h/%b want 0/0", thr, thr_wr); end
    checks++;
    for (int k = 0; k < NCH; k++) thr_m[k] = 16'h0;
    dat_m = 32'h0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_read_after_reset();
    logic [3:0] p;
    sts = '0;
    for (int k = 0; k < NCH; k++) begin
      p = model_txn(ADDR_W'(k), 1'b0, 4'hF, 32'h0);
      txn(ADDR_W'(k), 1'b0, 4'hF, 32'h0);
      if (o_dat !== 32'h0 || o_ack2 !== 1'b1 || o_err2 !== 1'b0) begin
        errors++; $display("FAIL rd0_%0d got dat %h ack %b err %b want 0 1 0", k, o_dat, o_ack2, o_err2);
      end
      checks++;
      if ({o_stall1, o_stall2, o_stall3, o_resp1, o_resp3} !== 5'b11000) begin
        errors++; $display("FAIL rd0_timing_%0d got %b want 11000", k, {o_stall1, o_stall2, o_stall3, o_resp1, o_resp3});
      end
      checks++;
    end
  endtask

  task automatic test_write_full();
    logic [3:0] p;
    p = model_txn(6'd2, 1'b1, 4'hF, 32'hDEAD_BEEF);
    txn(6'd2, 1'b1, 4'hF, 32'hDEAD_BEEF);
    if (o_thr !== thr_exp() || o_thr[47:32] !== 16'hBEEF) begin errors++; $display("FAIL wr_full_thr got %h want %h", o_thr, thr_exp()); end
    checks++;
    if (o_wr2 !== 4'b0100 || o_wr3 !== 4'b0000 || o_ack2 !== 1'b1) begin
      errors++; $display("FAIL wr_full_pulse got %b/%b ack %b want 0100/0000 1", o_wr2, o_wr3, o_ack2);
    end
    checks++;
  endtask

  task automatic test_byte_enable();
    logic [3:0] p;
    p = model_txn(6'd1, 1'b1, 4'h1, 32'h0000_1234);
    txn(6'd1, 1'b1, 4'h1, 32'h0000_1234);
    p = model_txn(6'd1, 1'b1, 4'h2, 32'h0000_AB00);
    txn(6'd1, 1'b1, 4'h2, 32'h0000_AB00);
    if (o_thr[31:16] !== 16'hAB34 || o_thr !== thr_exp()) begin errors++; $display("FAIL byte_en got %h want ab34", o_thr[31:16]); end
    checks++;
    p = model_txn(6'd1, 1'b1, 4'h0, 32'hFFFF_FFFF);
    txn(6'd1, 1'b1, 4'h0, 32'hFFFF_FFFF);
    if (o_thr !== thr_exp() || o_ack2 !== 1'b1 || o_wr2 !== 4'b0) begin
      errors++; $display("FAIL sel0 got thr %h ack %b wr %b want %h 1 0000", o_thr, o_ack2, o_wr2, thr_exp());
    end
    checks++;
    p = model_txn(6'd0, 1'b1, 4'hC, 32'h1234_5678);
    txn(6'd0, 1'b1, 4'hC, 32'h1234_5678);
    if (o_thr !== thr_exp() || o_wr2 !== 4'b0) begin errors++; $display("FAIL sel_hi got thr %h wr %b want %h 0000", o_thr, o_wr2, thr_exp()); end
    checks++;
  endtask

  task automatic test_status_read();
    logic [3:0] p;
    p = model_txn(6'd3, 1'b1, 4'h3, 32'h0000_0011);
    txn(6'd3, 1'b1, 4'h3, 32'h0000_0011);
    sts = 64'h5A5A_0000_0000_0000;
    p = model_txn(6'd3, 1'b0, 4'hF, 32'h0);
    txn(6'd3, 1'b0, 4'hF, 32'h0);
    if (o_dat !== 32'h5A5A_0011 || o_dat !== dat_m) begin errors++; $display("FAIL sts_read got %h want 5a5a0011", o_dat); end
    checks++;
  endtask

  task automatic test_miss();
    logic [3:0] p;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = (i < 2) ? ADDR_W'(NCH) : ADDR_W'($urandom_range(NCH, (1 << ADDR_W) - 1));
      we = 1'b0;
      p = model_txn(a, 1'(i % 2), 4'hF, $urandom);
      txn(a, 1'(i % 2), 4'hF, 32'hCAFE_F00D);
      if (o_err2 !== 1'b1 || o_ack2 !== 1'b0 || o_dat !== 32'h0) begin
        errors++; $display("FAIL miss_%0d adr %0d got err %b ack %b dat %h want 1 0 0", i, a, o_err2, o_ack2, o_dat);
      end
      checks++;
      if (o_thr !== thr_exp() || o_wr2 !== 4'b0 || o_resp3 !== 1'b0) begin
        errors++; $display("FAIL miss_side_%0d got thr %h wr %b want %h 0000", i, o_thr, o_wr2, thr_exp());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [3:0] p, s;
    logic [ADDR_W-1:0] a;
    logic w;
    logic [31:0] d;
    for (int i = 0; i < 60; i++) begin
      sts = {$urandom, $urandom};
      a = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 5));
      w = 1'($urandom);
      s = 4'($urandom);
      d = $urandom;
      p = model_txn(a, w, s, d);
      txn(a, w, s, d);
      if (o_dat !== dat_m || o_thr !== thr_exp() || o_wr2 !== p) begin
        errors++; $display("FAIL rand_%0d got dat %h thr %h wr %b want %h %h %b", i, o_dat, o_thr, o_wr2, dat_m, thr_exp(), p);
      end
      checks++;
      if (o_ack2 !== (int'(a) < NCH) || o_err2 !== (int'(a) >= NCH) || o_resp3 !== 1'b0 || o_wr3 !== 4'b0) begin
        errors++; $display("FAIL rand_resp_%0d got ack %b err %b want %b %b", i, o_ack2, o_err2, int'(a) < NCH, int'(a) >= NCH);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 6'd0; we = 1'b1; sel = 4'hF; wdat = 32'h0000_7777;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    seen = ack | err | (thr_wr != 4'b0) | stall;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      seen = seen | ack | err | stall;
    end
    for (int k = 0; k < NCH; k++) thr_m[k] = 16'h0;
    dat_m = 32'h0;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_resp got %b want 0", seen); end
    checks++;
    if (thr !== thr_exp() || rdat !== 32'h0) begin errors++; $display("FAIL rst_mid_thr got %h dat %h want %h 0", thr, rdat, thr_exp()); end
    checks++;
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    sts = 64'h0000_9999_0000_0000;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 6'd2; we = 1'b0; sel = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (ack !== (i % 3 == 2) || stall !== (i % 3 != 0)) begin
        errors++; $display("FAIL b2b_cyc%0d got ack %b stall %b want %b %b", i, ack, stall, i % 3 == 2, i % 3 != 0);
      end
      checks++;
      if (ack === 1'b1) begin
        acks++;
        if (rdat !== {16'h9999, thr_m[2]}) begin errors++; $display("FAIL b2b_dat got %h want %h", rdat, {16'h9999, thr_m[2]}); end
        checks++;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    if (acks !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", acks); end
    checks++;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_full();
    test_byte_enable();
    test_status_read();
    test_miss();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
